// File: rtl/pll_delay_cal.sv
// pll_delay_cal: sweeps the PLL fine-delay taps, finds the longest error-free run and parks at its centre
module pll_delay_cal #(
  parameter int TAP_W       = 4,
  parameter int SETTLE_CYC  = 256,
  parameter int WIN_CYC     = 4096,
  parameter int DEFAULT_TAP = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pll_lock,
  input  logic             chk_err,
  output logic [TAP_W-1:0] delay,
  output logic             busy,
  output logic             done,
  output logic             ok,
  output logic [TAP_W-1:0] win_lo,
  output logic [TAP_W:0]   win_len
);
  localparam int CNT_W = $clog2((SETTLE_CYC > WIN_CYC ? SETTLE_CYC : WIN_CYC) + 1);
  localparam logic [CNT_W-1:0] SET_END = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WIN_END = CNT_W'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TAP_W-1:0] DEF_TAP = TAP_W'(DEFAULT_TAP);
  localparam logic [TAP_W-1:0] TAP_MAX = '1;
  localparam logic [TAP_W-1:0] TAP_ONE = TAP_W'(1);
  localparam logic [TAP_W:0]   LEN_ONE = (TAP_W + 1)'(1);
  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, NEXT, FINAL} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             err_flag, abort, cnt_end;
  logic [TAP_W-1:0] cur_lo, best_lo, run_lo, centre;
  logic [TAP_W:0]   cur_len, best_len, run_len;
  assign abort   = state != IDLE && !pll_lock;
  assign cnt_end = cnt == (state == SETTLE ? SET_END : WIN_END);
  assign run_len = cur_len + LEN_ONE;
  assign run_lo  = cur_len == '0 ? delay : cur_lo;
  assign centre  = best_lo + TAP_W'((best_len - LEN_ONE) >> 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start && pll_lock ? SETTLE : IDLE;
      SETTLE:  nxt = cnt_end ? MEASURE : SETTLE;
      MEASURE: nxt = cnt_end ? NEXT : MEASURE;
      NEXT:    nxt = delay == TAP_MAX ? FINAL : SETTLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // every output is registered; abort wins over whatever the current state would do
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      delay    <= DEF_TAP;
      busy     <= 1'b0;
      done     <= 1'b0;
      ok       <= 1'b0;
      win_lo   <= '0;
      win_len  <= '0;
      cnt      <= '0;
      err_flag <= 1'b0;
      cur_lo   <= '0;
      cur_len  <= '0;
      best_lo  <= '0;
      best_len <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        delay <= DEF_TAP;
        done  <= 1'b1;
        busy  <= 1'b0;
        ok    <= 1'b0;
      end else
        case (state)
          IDLE:
            if (start) begin
              ok <= 1'b0;
              if (pll_lock) begin
                busy     <= 1'b1;
                delay    <= '0;
                cnt      <= '0;
                err_flag <= 1'b0;
                cur_lo   <= '0;
                cur_len  <= '0;
                best_lo  <= '0;
                best_len <= '0;
              end else done <= 1'b1;
            end
          SETTLE: cnt <= cnt_end ? '0 : cnt + CNT_ONE;
          MEASURE: begin
            cnt <= cnt_end ? '0 : cnt + CNT_ONE;
            if (chk_err) err_flag <= 1'b1;
          end
          NEXT: begin
            err_flag <= 1'b0;
            cur_len  <= err_flag ? '0 : run_len;
            if (!err_flag) cur_lo <= run_lo;
            if (!err_flag && run_len > best_len) begin
              best_lo  <= run_lo;
              best_len <= run_len;
            end
            if (delay != TAP_MAX) delay <= delay + TAP_ONE;
          end
          FINAL: begin
            busy    <= 1'b0;
            done    <= 1'b1;
            win_lo  <= best_lo;
            win_len <= best_len;
            ok      <= best_len != '0;
            delay   <= best_len != '0 ? centre : DEF_TAP;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_pll_delay_cal.sv
// tb_pll_delay_cal: directed and random tap sweeps checked against a window-search reference model
module tb_pll_delay_cal;
  logic       clk = 0, rst_n = 0, start = 0, pll_lock = 1, chk_err = 0;
  logic [3:0] delay, win_lo;
  logic       busy, done, ok;
  logic [4:0] win_len;
  int n_vec = 0, n_err = 0;
  int pick[16];
  int exp_lo = 0, exp_len = 0;
  pll_delay_cal #(.TAP_W(4), .SETTLE_CYC(4), .WIN_CYC(16), .DEFAULT_TAP(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pll_lock(pll_lock), .chk_err(chk_err),
    .delay(delay), .busy(busy), .done(done), .ok(ok), .win_lo(win_lo), .win_len(win_len)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask
  // brute force: longest all-pass run starting at each tap, earliest start wins ties
  function automatic void model(input logic [15:0] m, output int lo, output int len);
    lo = 0;
    len = 0;
    for (int s = 0; s < 16; s++) begin
      int l = 0;
      while (s + l < 16 && m[s+l]) l++;
      if (l > len) begin
        len = l;
        lo = s;
      end
    end
  endfunction
  // cycle n after the start edge: tap (n-1)/21, phase 0-3 settle, 4-19 measure, 20 next
  function automatic logic err_for(input int n, input logic [15:0] m, input bit noise);
    int t = (n - 1) / 21;
    int p = (n - 1) % 21;
    if (t > 15) return 1'b0;
    if (p < 4) return noise;
    if (p == 20) return noise & ($urandom_range(0, 1) == 1);
    return !m[t] && p == pick[t];
  endfunction
  task automatic sweep(input string tag, input logic [15:0] m, input bit noise, input int restart_at);
    int got = -1;
    int lo, len;
    model(m, lo, len);
    foreach (pick[i]) pick[i] = 4 + $urandom_range(0, 15);
    @(negedge clk);
    start = 1;
    chk_err = 0;
    @(posedge clk);
    for (int n = 1; n <= 400 && got < 0; n++) begin
      @(negedge clk);
      start = n == restart_at;
      chk_err = err_for(n, m, noise);
      @(posedge clk);
      #1;
      if (n == 1) begin
        chk({tag, " busy"}, busy, 1);
        chk({tag, " delay0"}, delay, 0);
      end
      if (done) got = n;
    end
    start = 0;
    chk_err = 0;
    chk({tag, " latency"}, got, 337);
    chk({tag, " ok"}, ok, len > 0);
    chk({tag, " win_len"}, win_len, len);
    if (len > 0) chk({tag, " win_lo"}, win_lo, lo);
    chk({tag, " delay"}, delay, len > 0 ? lo + (len - 1) / 2 : 15);
    chk({tag, " busy end"}, busy, 0);
    exp_lo = lo;
    exp_len = len;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk({tag, " done pulse"}, done, 0);
  endtask
  initial begin
    int dones;
    #12;
    chk("rst delay", delay, 15);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst ok", ok, 0);
    chk("rst win_lo", win_lo, 0);
    chk("rst win_len", win_len, 0);
    @(negedge clk);
    rst_n = 1;
    sweep("allpass", 16'hFFFF, 0, 0);
    @(negedge clk);
    start = 1;
    pll_lock = 0;
    @(posedge clk);
    #1;
    chk("nolock done", done, 1);
    chk("nolock ok", ok, 0);
    chk("nolock delay", delay, 7);
    chk("nolock busy", busy, 0);
    @(negedge clk);
    start = 0;
    pll_lock = 1;
    @(posedge clk);
    #1;
    chk("nolock done pulse", done, 0);
    sweep("mid", 16'h07F0, 0, 0);
    sweep("tie", 16'h070E, 0, 0);
    sweep("allfail", 16'h0000, 0, 0);
    sweep("settle_noise", 16'hFFFF, 1, 0);
    for (int r = 0; r < 4; r++) sweep($sformatf("rand%0d", r), 16'($urandom), 1'($urandom_range(0, 1)), 0);
    sweep("restart_ignored", 16'h3C3C, 0, 50);
    @(negedge clk);
    start = 1;
    @(posedge clk);
    for (int n = 1; n <= 115; n++) begin
      @(negedge clk);
      start = 0;
      pll_lock = n != 115;
      @(posedge clk);
      #1;
    end
    chk("abort done", done, 1);
    chk("abort busy", busy, 0);
    chk("abort ok", ok, 0);
    chk("abort delay", delay, 15);
    chk("abort win_lo", win_lo, exp_lo);
    chk("abort win_len", win_len, exp_len);
    @(negedge clk);
    pll_lock = 1;
    @(posedge clk);
    #1;
    chk("abort done pulse", done, 0);
    sweep("after_abort", 16'h07F0, 0, 0);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (60) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst delay", delay, 15);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst ok", ok, 0);
    chk("midrst win_lo", win_lo, 0);
    chk("midrst win_len", win_len, 0);
    @(negedge clk);
    rst_n = 1;
    dones = 0;
    repeat (400) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    chk("midrst quiet", dones, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
